ld_to_affine: RTL and testbench

LD_TO_AFFINE -- requirements
Module: ld_to_affine

---
 rtl/ld_to_affine_pkg.sv | 21 ++
 rtl/multiplier_163b.sv | 30 +++
 rtl/ld_to_affine.sv | 171 +++++++++++++++++
 tb/tb_ld_to_affine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ld_to_affine_pkg.sv
// Shared definitions for the Lopez-Dahab to affine converter: field width,
// B-163 reduction polynomial and FSM state encoding.
package ld_to_affine_pkg;

    localparam int unsigned GF_M = 163;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1; the x^163 term is implicit
    localparam logic [GF_M-1:0] POLY_LOW = GF_M'(8'hC9);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        INV_REQ  = 3'd2,
        INV_WAIT = 3'd3,
        MUL_X    = 3'd4,
        SQ_ZI    = 3'd5,
        MUL_Y    = 3'd6,
        DONE     = 3'd7
    } state_e;

endpackage

// File: rtl/multiplier_163b.sv
// Combinational GF(2^M) multiplier, MSB-first shift-and-add with on-the-fly
// reduction modulo the B-163 polynomial.
module multiplier_163b
    import ld_to_affine_pkg::*;
#(
    parameter int unsigned M = GF_M
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] prod_c_o
);

    localparam int unsigned  IW   = $clog2(M);
    localparam logic [M-1:0] POLY = M'(POLY_LOW);

    logic [M-1:0] acc;

    // Horner evaluation: acc = acc*x mod f, then add a when the b bit is set
    always_comb begin
        acc = '0;
        for (int i = int'(M) - 1; i >= 0; i--) begin
            acc = {acc[M-2:0], 1'b0} ^ ({M{acc[M-1]}} & POLY);
            if (b_i[IW'(i)]) begin
                acc = acc ^ a_i;
            end
        end
        prod_c_o = acc;
    end

endmodule

// File: rtl/ld_to_affine.sv
// Converts a Lopez-Dahab projective point to affine (x = X/Z, y = Y/Z^2)
// using an external inverter. Define LD_AFFINE_Y_EN to also produce y_aff.
module ld_to_affine
    import ld_to_affine_pkg::*;
#(
    parameter int unsigned M = GF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] X_in,
    input  logic [M-1:0] Y_in,
    input  logic [M-1:0] Z_in,
    output logic         inv_start,
    output logic [M-1:0] inv_operand,
    input  logic         inv_done,
    input  logic [M-1:0] inv_result,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] x_aff,
    output logic [M-1:0] y_aff,
    output logic         inf
);

    state_e       state_q;
    logic         busy_q;
    logic         done_q;
    logic         inv_start_q;
    logic         inf_q;
    logic [M-1:0] x_q;
    logic [M-1:0] z_q;
    logic [M-1:0] zi_q;
    logic [M-1:0] xa_q;
    logic [M-1:0] mul_a;
    logic [M-1:0] mul_b;
    logic [M-1:0] mul_p_c;
`ifdef LD_AFFINE_Y_EN
    logic [M-1:0] y_q;
    logic [M-1:0] t_q;
    logic [M-1:0] ya_q;
`else
    logic         unused_y_in;
    assign unused_y_in = ^Y_in;
`endif

    // Shared multiplier operands follow the arithmetic state
    always_comb begin
        mul_a = x_q;
        mul_b = zi_q;
`ifdef LD_AFFINE_Y_EN
        case (state_q)
            SQ_ZI: begin
                mul_a = zi_q;
                mul_b = zi_q;
            end
            MUL_Y: begin
                mul_a = y_q;
                mul_b = t_q;
            end
            default: ;
        endcase
`endif
    end

    multiplier_163b #(.M(M)) u_mul (
        .a_i      (mul_a),
        .b_i      (mul_b),
        .prod_c_o (mul_p_c)
    );

    // Control FSM; done and inv_start are registered on entry to their states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inv_start_q <= 1'b0;
            inf_q       <= 1'b0;
            x_q         <= '0;
            z_q         <= '0;
            zi_q        <= '0;
            xa_q        <= '0;
`ifdef LD_AFFINE_Y_EN
            y_q         <= '0;
            t_q         <= '0;
            ya_q        <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            inv_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= X_in;
                        z_q     <= Z_in;
`ifdef LD_AFFINE_Y_EN
                        y_q     <= Y_in;
`endif
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (z_q == '0) begin
                        inf_q   <= 1'b1;
                        xa_q    <= '0;
`ifdef LD_AFFINE_Y_EN
                        ya_q    <= '0;
`endif
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        inf_q       <= 1'b0;
                        inv_start_q <= 1'b1;
                        state_q     <= INV_REQ;
                    end
                end
                INV_REQ: begin
                    state_q <= INV_WAIT;
                end
                INV_WAIT: begin
                    if (inv_done) begin
                        zi_q    <= inv_result;
                        state_q <= MUL_X;
                    end
                end
                MUL_X: begin
                    xa_q <= mul_p_c;
`ifdef LD_AFFINE_Y_EN
                    state_q <= SQ_ZI;
`else
                    done_q  <= 1'b1;
                    state_q <= DONE;
`endif
                end
`ifdef LD_AFFINE_Y_EN
                SQ_ZI: begin
                    t_q     <= mul_p_c;
                    state_q <= MUL_Y;
                end
                MUL_Y: begin
                    ya_q    <= mul_p_c;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inv_start   = inv_start_q;
    assign inv_operand = z_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign x_aff       = xa_q;
    assign inf         = inf_q;
`ifdef LD_AFFINE_Y_EN
    assign y_aff       = ya_q;
`else
    assign y_aff       = '0;
`endif

endmodule

// File: tb/tb_ld_to_affine.sv
// Self-checking bench for ld_to_affine: directed conversions against a
// polynomial-product reference model, checked every cycle.
module tb_ld_to_affine;

    localparam int unsigned M = 163;
`ifdef LD_AFFINE_Y_EN
    localparam int LAT = 4;
    localparam bit YEN = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit YEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] X_in, Y_in, Z_in;
    logic         inv_start;
    logic [M-1:0] inv_operand;
    logic         inv_done;
    logic [M-1:0] inv_result;
    logic         busy, done, inf;
    logic [M-1:0] x_aff, y_aff;

    ld_to_affine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .X_in        (X_in),
        .Y_in        (Y_in),
        .Z_in        (Z_in),
        .inv_start   (inv_start),
        .inv_operand (inv_operand),
        .inv_done    (inv_done),
        .inv_result  (inv_result),
        .busy        (busy),
        .done        (done),
        .x_aff       (x_aff),
        .y_aff       (y_aff),
        .inf         (inf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected state of the current/last conversion
    bit           m_active = 1'b0;
    bit           m_zero   = 1'b0;
    int           m_s      = 0;
    int           m_done_r = 0;
    logic [M-1:0] m_z      = '0;
    logic [M-1:0] exp_x    = '0;
    logic [M-1:0] exp_y    = '0;
    logic         exp_inf  = 1'b0;
    int           obs_done_cnt = 0;
    int           obs_done_r   = 0;

    task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference: full carry-less product, then long division by f
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [2*M-2:0] f;
        logic [2*M-2:0] ax;
        p  = '0;
        f  = '0;
        f[M] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        ax = {{(M-1){1'b0}}, a};
        for (int i = 0; i < int'(M); i++)
            if (b[i]) p = p ^ (ax << i);
        for (int k = 2*int'(M) - 2; k >= int'(M); k--)
            if (p[k]) p = p ^ (f << (k - int'(M)));
        return p[M-1:0];
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int r;
        bit e_busy, e_done, e_invs;
        r      = cyc + 1 - m_s;
        e_busy = m_active && (r >= 1) && (r <= m_done_r);
        e_done = m_active && (r == m_done_r);
        e_invs = m_active && !m_zero && (r == 2);
        chk("busy", M'(busy), M'(e_busy));
        chk("done", M'(done), M'(e_done));
        chk("inv_start", M'(inv_start), M'(e_invs));
        if (e_busy)
            chk("inv_operand", inv_operand, m_z);
        if (!e_busy || e_done) begin
            chk("x_aff", x_aff, exp_x);
            chk("y_aff", y_aff, exp_y);
            chk("inf", M'(inf), M'(exp_inf));
        end
        if (done === 1'b1) begin
            obs_done_cnt++;
            obs_done_r = r;
        end
    end

    task automatic conv(input logic [M-1:0] x, input logic [M-1:0] y, input logic [M-1:0] z,
                        input logic [M-1:0] zi, input int n_rel, input bit hold, input bit spur);
        @(posedge clk); #1;
        X_in = x; Y_in = y; Z_in = z; start = 1'b1;
        @(posedge clk); #1;
        m_s      = cyc;
        m_z      = z;
        m_zero   = (z == '0);
        m_done_r = m_zero ? 2 : n_rel + LAT;
        if (m_zero) begin
            exp_x = '0; exp_y = '0; exp_inf = 1'b1;
        end else begin
            exp_x   = ref_mul(x, zi);
            exp_y   = YEN ? ref_mul(y, ref_mul(zi, zi)) : '0;
            exp_inf = 1'b0;
        end
        m_active = 1'b1;
        if (!hold) start = 1'b0;
        if (!m_zero) begin
            repeat (n_rel - 1) @(posedge clk);
            #1;
            inv_result = zi; inv_done = 1'b1;
            @(posedge clk); #1;
            if (spur) begin
                inv_result = ~zi;
                @(posedge clk); #1;
            end
            inv_done = 1'b0; inv_result = '0;
        end
        while (cyc < m_s + m_done_r - 1) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [M-1:0] inv2, hi, pa, pb, pc, pd;
        int c0, s;

        rst = 1'b0; start = 1'b0; inv_done = 1'b0;
        X_in = '0; Y_in = '0; Z_in = '0; inv_result = '0;

        inv2 = '0; inv2[162] = 1'b1; inv2[6] = 1'b1; inv2[5] = 1'b1; inv2[2] = 1'b1;
        hi   = '0; hi[162] = 1'b1;
        pa = {M{1'b1}};
        pb = {{81{2'b10}}, 1'b1};
        pc = {{40{4'hA}}, 3'b101};
        pd = {1'b1, {(M-2){1'b0}}, 1'b1};

        // Hand-derived pins of the reference model
        chk("model x^162*x", ref_mul(hi, M'(2)), M'(8'hC9));
        chk("model 2*inv2", ref_mul(M'(2), inv2), M'(1));

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        conv(M'(2), M'(3), M'(1), M'(1), 7, 1'b0, 1'b0);
        chk("basic x_aff", x_aff, M'(2));
        chk("basic y_aff", y_aff, YEN ? M'(3) : M'(0));
        chk("basic done cycle", M'(obs_done_r), M'(7 + LAT));

        conv(M'(5), M'(6), M'(0), M'(0), 0, 1'b0, 1'b0);
        chk("inf flag", M'(inf), M'(1));
        chk("inf x_aff", x_aff, M'(0));
        chk("inf done cycle", M'(obs_done_r), M'(2));

        conv(M'(2), pc, M'(2), inv2, 4, 1'b0, 1'b0);
        chk("z2 x_aff", x_aff, M'(1));

        conv(pa, pb, pc, pd, 3, 1'b0, 1'b0);
        conv(pd, pa, M'(1), pb, 9, 1'b0, 1'b0);

        c0 = obs_done_cnt;
        conv(pb, pd, pa, pc, 6, 1'b1, 1'b1);
        chk("single done", M'(obs_done_cnt), M'(c0 + 1));

        // Reset while waiting on the inverter
        c0 = obs_done_cnt;
        @(posedge clk); #1;
        X_in = M'(7); Y_in = M'(9); Z_in = M'(3); start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        m_s = s; m_z = M'(3); m_zero = 1'b0; m_done_r = 1000; m_active = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        m_active = 1'b0; exp_x = '0; exp_y = '0; exp_inf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        inv_result = M'(5); inv_done = 1'b1;
        @(posedge clk); #1;
        inv_done = 1'b0; inv_result = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset no done", M'(obs_done_cnt), M'(c0));
        chk("reset busy", M'(busy), M'(0));
        chk("reset x_aff", x_aff, M'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
